// File: rtl/alu_pkg.sv
// ALU function codes shared by the ALU datapath and its command sequencer.
package alu_pkg;
   typedef enum logic [3:0] {
      ALU_ADD   = 4'h0,
      ALU_SUB   = 4'h1,
      ALU_MUL   = 4'h2,
      ALU_DIV   = 4'h3,
      ALU_AND   = 4'h4,
      ALU_OR    = 4'h5,
      ALU_NAND  = 4'h6,
      ALU_NOR   = 4'h7,
      ALU_XOR   = 4'h8,
      ALU_XNOR  = 4'h9,
      ALU_CMPEQ = 4'hA,
      ALU_CMPGT = 4'hB,
      ALU_CMPLT = 4'hC,
      ALU_SHR   = 4'hD,
      ALU_SHL   = 4'hE,
      ALU_RSVD  = 4'hF
   } alu_op_e;
endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Byte-stream, TX handshake and ALU port bundle around the command sequencer.
interface alu_cmd_sequencer_if #(
   parameter int OPER_WIDTH = 8,
   parameter int OUT_WIDTH  = 16
);
   import alu_pkg::*;

   logic [7:0]            RX_DATA;
   logic                  RX_VALID;
   logic [7:0]            TX_DATA;
   logic                  TX_VALID;
   logic                  TX_READY;
   logic [OPER_WIDTH-1:0] ALU_A;
   logic [OPER_WIDTH-1:0] ALU_B;
   alu_op_e               ALU_FUN;
   logic                  ALU_EN;
   logic [OUT_WIDTH-1:0]  ALU_OUT;
   logic                  ALU_VALID;
   logic                  BUSY;
   logic                  ERR;

   // sequencer side
   modport master (
      input  RX_DATA, RX_VALID, TX_READY, ALU_OUT, ALU_VALID,
      output TX_DATA, TX_VALID, ALU_A, ALU_B, ALU_FUN, ALU_EN, BUSY, ERR
   );

   // UART / ALU side
   modport slave (
      output RX_DATA, RX_VALID, TX_READY, ALU_OUT, ALU_VALID,
      input  TX_DATA, TX_VALID, ALU_A, ALU_B, ALU_FUN, ALU_EN, BUSY, ERR
   );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Parses CC/DD operation frames from the RX byte stream, drives the ALU,
// and returns the 16-bit result as LSB then MSB over the TX handshake.
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int OPER_WIDTH = 8,
   parameter int OUT_WIDTH  = 16,
   parameter int TIMEOUT    = 1024
) (
   input logic              CLK,
   input logic              RST,
   alu_cmd_sequencer_if.master bus
);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE, GET_A, GET_B, GET_FUN, EXEC, WAIT_RES, SEND_LO, SEND_HI
   } state_e;

   state_e                state_q, state_d;
   logic [OPER_WIDTH-1:0] a_q, a_d, b_q, b_d;
   alu_op_e               fun_q, fun_d;
   logic [OUT_WIDTH-1:0]  res_q, res_d;
   logic [CW-1:0]         tmo_q, tmo_d;
   logic [7:0]            tx_data_q, tx_data_d;
   logic                  tx_valid_q, tx_valid_d;
   logic                  en_q, en_d;
   logic                  busy_q, busy_d;
   logic                  err_q, err_d;
   logic                  fun_ok, tmo_hit, get_st;

   assign fun_ok  = (bus.RX_DATA[7:4] == 4'h0) && (bus.RX_DATA[3:0] != 4'hF);
   assign tmo_hit = (tmo_q == CW'(TIMEOUT - 1));
   assign get_st  = (state_q == GET_A) || (state_q == GET_B) || (state_q == GET_FUN);

   // next state, operand/result capture, timeout and registered outputs
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      fun_d   = fun_q;
      res_d   = res_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: if (bus.RX_VALID) begin
            if (bus.RX_DATA == 8'hCC)      state_d = GET_A;
            else if (bus.RX_DATA == 8'hDD) state_d = GET_FUN;
         end
         GET_A: if (bus.RX_VALID) begin
            a_d     = bus.RX_DATA;
            state_d = GET_B;
         end else if (tmo_hit) begin
            err_d   = 1'b1;
            state_d = IDLE;
         end
         GET_B: if (bus.RX_VALID) begin
            b_d     = bus.RX_DATA;
            state_d = GET_FUN;
         end else if (tmo_hit) begin
            err_d   = 1'b1;
            state_d = IDLE;
         end
         GET_FUN: if (bus.RX_VALID) begin
            if (fun_ok) begin
               fun_d   = alu_op_e'(bus.RX_DATA[3:0]);
               state_d = EXEC;
            end else begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end else if (tmo_hit) begin
            err_d   = 1'b1;
            state_d = IDLE;
         end
         EXEC: state_d = WAIT_RES;
         WAIT_RES: if (bus.ALU_VALID) begin
            res_d   = bus.ALU_OUT;
            state_d = SEND_LO;
         end else if (tmo_hit) begin
            err_d   = 1'b1;
            state_d = IDLE;
         end
         SEND_LO: if (bus.TX_READY) state_d = SEND_HI;
         SEND_HI: if (bus.TX_READY) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // bytes arriving while the operation is in flight are dropped
      if (bus.RX_VALID && !get_st && state_q != IDLE) err_d = 1'b1;

      // counter restarts on state entry and on every byte within a frame
      if (state_d != state_q || (bus.RX_VALID && get_st)) tmo_d = '0;
      else if (get_st || state_q == WAIT_RES)              tmo_d = tmo_q + 1'b1;
      else                                                 tmo_d = '0;

      // ALU_EN follows EXEC by one cycle so all outputs come from flops
      en_d       = (state_q == EXEC);
      tx_valid_d = (state_d == SEND_LO) || (state_d == SEND_HI);
      busy_d     = (state_d != IDLE);
      tx_data_d  = 8'h00;
      if (state_d == SEND_LO)      tx_data_d = res_d[7:0];
      else if (state_d == SEND_HI) tx_data_d = res_q[15:8];
   end

   // state and output registers
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         fun_q      <= ALU_ADD;
         res_q      <= '0;
         tmo_q      <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         en_q       <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         fun_q      <= fun_d;
         res_q      <= res_d;
         tmo_q      <= tmo_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         en_q       <= en_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
      end
   end

   assign bus.ALU_A    = a_q;
   assign bus.ALU_B    = b_q;
   assign bus.ALU_FUN  = fun_q;
   assign bus.ALU_EN   = en_q;
   assign bus.TX_DATA  = tx_data_q;
   assign bus.TX_VALID = tx_valid_q;
   assign bus.BUSY     = busy_q;
   assign bus.ERR      = err_q;
endmodule
